// File: rtl/custom_busmatrix_pkg.sv
// Shared AHB encodings, hold-register layout and FSM state type for the bus-matrix input stage.
package custom_busmatrix_pkg;

   localparam logic [1:0] TRANS_IDLE   = 2'b00;
   localparam logic [1:0] TRANS_BUSY   = 2'b01;
   localparam logic [1:0] TRANS_NONSEQ = 2'b10;
   localparam logic [1:0] TRANS_SEQ    = 2'b11;

   localparam logic [1:0] RESP_OKAY    = 2'b00;
   localparam logic [1:0] RESP_ERROR   = 2'b01;

   localparam int HOLD_W = 45;

   typedef enum logic {
      ST_PASS = 1'b0,
      ST_HOLD = 1'b1
   } instg_state_e;

   // Field order sets the bit layout of the 45-bit capture register.
   typedef struct packed {
      logic [31:0] addr;
      logic [1:0]  trans;
      logic        write;
      logic [2:0]  size;
      logic [2:0]  burst;
      logic [3:0]  prot;
   } hold_fields_t;

endpackage

// File: rtl/custom_busmatrix_hold_reg.sv
// Capture register for one address-phase transfer; loads on load_en, clears on async reset.
module custom_busmatrix_hold_reg
   import custom_busmatrix_pkg::*;
(
   input  logic              HCLK,
   input  logic              HRESETn,
   input  logic              load_en,
   input  logic [HOLD_W-1:0] hold_d,
   output logic [HOLD_W-1:0] hold_q
);

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         hold_q <= '0;
      end else if (load_en) begin
         hold_q <= hold_d;
      end
   end

endmodule

// File: rtl/custom_busmatrix_input_stage.sv
// Bus-matrix input stage: passes a master's address phase straight through, or holds it while
// the output stage is not granted. Optional macro: CUSTOM_BUSMATRIX_INSTG_ERR_CANCEL_EN.
module custom_busmatrix_input_stage
   import custom_busmatrix_pkg::*;
(
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        HSELS,
   input  logic [31:0] HADDRS,
   input  logic [1:0]  HTRANSS,
   input  logic        HWRITES,
   input  logic [2:0]  HSIZES,
   input  logic [2:0]  HBURSTS,
   input  logic [3:0]  HPROTS,
   input  logic        HREADYS,
   output logic        HREADYOUTS,
   output logic [1:0]  HRESPS,
   output logic        sel_op,
   output logic [31:0] addr_op,
   output logic [1:0]  trans_op,
   output logic        write_op,
   output logic [2:0]  size_op,
   output logic [2:0]  burst_op,
   output logic [3:0]  prot_op,
   output logic        held_tran_op,
   input  logic        active_dec,
   input  logic        readyout_dec,
   input  logic [1:0]  resp_dec,
   output logic        state_dbg
);

   instg_state_e state_q;
   instg_state_e state_d;
   hold_fields_t live;
   hold_fields_t held;
   logic [HOLD_W-1:0] hold_q;
   logic valid_sample;
   logic err_cancel;

   assign valid_sample = HSELS & HREADYS & HTRANSS[1];
   assign state_dbg    = state_q;

   assign live = '{addr: HADDRS, trans: HTRANSS, write: HWRITES,
                   size: HSIZES, burst: HBURSTS, prot: HPROTS};
   assign held = hold_fields_t'(hold_q);

`ifdef CUSTOM_BUSMATRIX_INSTG_ERR_CANCEL_EN
   // First error cycle of the previous transfer: drop the held one instead of waiting for a grant.
   assign err_cancel = (state_q == ST_HOLD) && !active_dec &&
                       (resp_dec == RESP_ERROR) && !readyout_dec;
`else
   assign err_cancel = 1'b0;
`endif

   custom_busmatrix_hold_reg u_hold_reg (
      .HCLK    (HCLK),
      .HRESETn (HRESETn),
      .load_en (valid_sample),
      .hold_d  (live),
      .hold_q  (hold_q)
   );

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q <= ST_PASS;
      end else begin
         state_q <= state_d;
      end
   end

   // addr_op is combinational so addr_op[31:10] can feed decode_addr_dec with no added latency.
   always_comb begin
      state_d      = state_q;
      sel_op       = HSELS;
      addr_op      = live.addr;
      trans_op     = live.trans;
      write_op     = live.write;
      size_op      = live.size;
      burst_op     = live.burst;
      prot_op      = live.prot;
      held_tran_op = 1'b0;
      HREADYOUTS   = readyout_dec;
      HRESPS       = resp_dec;

      case (state_q)
         ST_PASS: begin
            if (valid_sample && !active_dec) state_d = ST_HOLD;
         end
         ST_HOLD: begin
            if (active_dec || err_cancel) state_d = ST_PASS;
            sel_op       = 1'b1;
            addr_op      = held.addr;
            // A held SEQ lost arbitration, so it restarts the burst as NONSEQ.
            trans_op     = (held.trans == TRANS_SEQ) ? TRANS_NONSEQ : held.trans;
            write_op     = held.write;
            size_op      = held.size;
            burst_op     = held.burst;
            prot_op      = held.prot;
            held_tran_op = 1'b1;
            HREADYOUTS   = 1'b0;
            HRESPS       = RESP_OKAY;
            if (err_cancel) trans_op = TRANS_IDLE;
         end
         default: state_d = ST_PASS;
      endcase
   end

   // HREADYOUTS is low in HOLD, so the master cannot present a new sample on the exit edge.
   assert property (@(posedge HCLK) disable iff (!HRESETn)
      !((state_q == ST_HOLD) && (state_d == ST_PASS) && valid_sample));

endmodule

// File: tb/tb_custom_busmatrix_input_stage.sv
// Directed bench for the bus-matrix input stage with a queued expected-response scoreboard.
module tb_custom_busmatrix_input_stage;
   import custom_busmatrix_pkg::*;

   localparam int EXP_W = 51;

   logic        HCLK = 1'b0;
   logic        HRESETn;
   logic        HSELS;
   logic [31:0] HADDRS;
   logic [1:0]  HTRANSS;
   logic        HWRITES;
   logic [2:0]  HSIZES;
   logic [2:0]  HBURSTS;
   logic [3:0]  HPROTS;
   logic        HREADYS;
   logic        HREADYOUTS;
   logic [1:0]  HRESPS;
   logic        sel_op;
   logic [31:0] addr_op;
   logic [1:0]  trans_op;
   logic        write_op;
   logic [2:0]  size_op;
   logic [2:0]  burst_op;
   logic [3:0]  prot_op;
   logic        held_tran_op;
   logic        active_dec;
   logic        readyout_dec;
   logic [1:0]  resp_dec;
   logic        state_dbg;

   logic [EXP_W-1:0] exp_q[$];
   string            name_q[$];
   int               checks = 0;
   int               errors = 0;

   custom_busmatrix_input_stage dut (
      .HCLK         (HCLK),
      .HRESETn      (HRESETn),
      .HSELS        (HSELS),
      .HADDRS       (HADDRS),
      .HTRANSS      (HTRANSS),
      .HWRITES      (HWRITES),
      .HSIZES       (HSIZES),
      .HBURSTS      (HBURSTS),
      .HPROTS       (HPROTS),
      .HREADYS      (HREADYS),
      .HREADYOUTS   (HREADYOUTS),
      .HRESPS       (HRESPS),
      .sel_op       (sel_op),
      .addr_op      (addr_op),
      .trans_op     (trans_op),
      .write_op     (write_op),
      .size_op      (size_op),
      .burst_op     (burst_op),
      .prot_op      (prot_op),
      .held_tran_op (held_tran_op),
      .active_dec   (active_dec),
      .readyout_dec (readyout_dec),
      .resp_dec     (resp_dec),
      .state_dbg    (state_dbg)
   );

   // clock / reset
   always #5 HCLK = ~HCLK;

   function automatic logic [EXP_W-1:0] pack(
      input logic st, input logic sel, input logic [31:0] addr, input logic [1:0] trans,
      input logic wr, input logic [2:0] sz, input logic [2:0] bu, input logic [3:0] pr,
      input logic held, input logic hro, input logic [1:0] hrs);
      return {st, sel, addr, trans, wr, sz, bu, pr, held, hro, hrs};
   endfunction

   // driver tasks
   task automatic step();
      @(posedge HCLK);
      #1;
   endtask

   task automatic drive(
      input logic sel, input logic [31:0] addr, input logic [1:0] trans, input logic wr,
      input logic [2:0] sz, input logic [2:0] bu, input logic [3:0] pr, input logic rdy,
      input logic act, input logic rdo, input logic [1:0] rsp);
      HSELS = sel; HADDRS = addr; HTRANSS = trans; HWRITES = wr;
      HSIZES = sz; HBURSTS = bu; HPROTS = pr; HREADYS = rdy;
      active_dec = act; readyout_dec = rdo; resp_dec = rsp;
   endtask

   // PASS state: every decoder/master output is the corresponding live input just driven.
   task automatic exp_pass(input string nm);
      exp_q.push_back(pack(1'b0, HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS,
                           1'b0, readyout_dec, resp_dec));
      name_q.push_back(nm);
   endtask

   task automatic exp_hold(input string nm, input logic [31:0] addr, input logic [1:0] trans,
                           input logic wr, input logic [2:0] sz, input logic [2:0] bu,
                           input logic [3:0] pr);
      exp_q.push_back(pack(1'b1, 1'b1, addr, trans, wr, sz, bu, pr, 1'b1, 1'b0, RESP_OKAY));
      name_q.push_back(nm);
   endtask

   // scoreboard monitor
   always @(negedge HCLK) begin
      logic [EXP_W-1:0] e;
      logic [EXP_W-1:0] got;
      string            nm;
      while (exp_q.size() > 0) begin
         e   = exp_q.pop_front();
         nm  = name_q.pop_front();
         got = pack(state_dbg, sel_op, addr_op, trans_op, write_op, size_op, burst_op,
                    prot_op, held_tran_op, HREADYOUTS, HRESPS);
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL %s got=%h exp=%h (state,sel,addr,trans,wr,size,burst,prot,held,hready,hresp)",
                     nm, got, e);
         end
      end
   end

   initial begin
      HRESETn = 1'b0;
      drive(1'b0, 32'h0, TRANS_IDLE, 1'b0, 3'd0, 3'd0, 4'h0, 1'b1, 1'b0, 1'b1, RESP_OKAY);
      #2;
      exp_pass("reset_outputs");
      repeat (2) @(posedge HCLK);
      #1 HRESETn = 1'b1;

      // S1: granted NONSEQ passes with zero latency
      step(); drive(1'b1, 32'h5000_0010, TRANS_NONSEQ, 1'b1, 3'd2, 3'd0, 4'h3, 1'b1, 1'b1, 1'b1, RESP_OKAY);
      exp_pass("s1_nonseq_pass");
      step(); drive(1'b0, 32'h5000_0014, TRANS_IDLE, 1'b0, 3'd2, 3'd0, 4'h3, 1'b1, 1'b1, 1'b0, RESP_OKAY);
      exp_pass("s1_ready_follows");

      // S2: not granted -> HOLD for three cycles, then grant
      step(); drive(1'b1, 32'h5004_C004, TRANS_NONSEQ, 1'b0, 3'd2, 3'd3, 4'h2, 1'b1, 1'b0, 1'b1, RESP_OKAY);
      exp_pass("s2_issue");
      for (int i = 0; i < 3; i++) begin
         step(); drive(1'b1, 32'h1111_0000 + 32'(i * 4), TRANS_NONSEQ, 1'b1, 3'd1, 3'd1, 4'h1,
                       1'b0, 1'b0, 1'b1, RESP_ERROR);
         exp_hold($sformatf("s2_hold_%0d", i), 32'h5004_C004, TRANS_NONSEQ, 1'b0, 3'd2, 3'd3, 4'h2);
      end
      step(); drive(1'b1, 32'h2222_0000, TRANS_NONSEQ, 1'b1, 3'd1, 3'd1, 4'h1, 1'b0, 1'b1, 1'b1, RESP_OKAY);
      exp_hold("s2_grant_cycle", 32'h5004_C004, TRANS_NONSEQ, 1'b0, 3'd2, 3'd3, 4'h2);
      step(); drive(1'b1, 32'h5004_C008, TRANS_IDLE, 1'b0, 3'd2, 3'd3, 4'h2, 1'b1, 1'b1, 1'b1, RESP_OKAY);
      exp_pass("s2_pass_restored");

      // S3: held SEQ is presented as NONSEQ
      step(); drive(1'b1, 32'h5000_0014, TRANS_SEQ, 1'b1, 3'd2, 3'd3, 4'h3, 1'b1, 1'b0, 1'b1, RESP_OKAY);
      exp_pass("s3_issue_seq");
      step(); drive(1'b1, 32'h5000_0018, TRANS_SEQ, 1'b0, 3'd0, 3'd0, 4'h0, 1'b0, 1'b0, 1'b1, RESP_OKAY);
      exp_hold("s3_seq_as_nonseq", 32'h5000_0014, TRANS_NONSEQ, 1'b1, 3'd2, 3'd3, 4'h3);

      // S4: reset in HOLD drops the held transfer without a clock edge
      step(); drive(1'b1, 32'h0000_00A0, TRANS_NONSEQ, 1'b0, 3'd0, 3'd0, 4'h0, 1'b0, 1'b0, 1'b1, 2'b10);
      #1 HRESETn = 1'b0;
      exp_pass("s4_reset_in_hold");
      step(); HRESETn = 1'b1;
      checks++;
      if (dut.u_hold_reg.hold_q !== '0) begin
         errors++;
         $display("FAIL s4_hold_reg_cleared got=%h exp=0", dut.u_hold_reg.hold_q);
      end
      drive(1'b0, 32'h0, TRANS_IDLE, 1'b0, 3'd0, 3'd0, 4'h0, 1'b1, 1'b0, 1'b1, RESP_OKAY);
      exp_pass("s4_pass_after_release");

      // S6: IDLE and BUSY are never held
      step(); drive(1'b1, 32'h0000_0060, TRANS_IDLE, 1'b0, 3'd0, 3'd0, 4'h0, 1'b1, 1'b0, 1'b1, RESP_OKAY);
      exp_pass("s6_idle_pass");
      step(); drive(1'b1, 32'h0000_0064, TRANS_BUSY, 1'b0, 3'd0, 3'd0, 4'h0, 1'b1, 1'b0, 1'b0, RESP_OKAY);
      exp_pass("s6_busy_pass");
      step(); drive(1'b0, 32'h0000_0068, TRANS_IDLE, 1'b0, 3'd0, 3'd0, 4'h0, 1'b1, 1'b0, 1'b1, RESP_OKAY);
      exp_pass("s6_no_hold");

      // S5: error response while holding
      step(); drive(1'b1, 32'h5000_0020, TRANS_NONSEQ, 1'b1, 3'd2, 3'd0, 4'h3, 1'b1, 1'b0, 1'b1, RESP_OKAY);
      exp_pass("s5_issue");
      step(); drive(1'b1, 32'h5000_0024, TRANS_NONSEQ, 1'b1, 3'd2, 3'd0, 4'h3, 1'b0, 1'b0, 1'b0, RESP_ERROR);
`ifdef CUSTOM_BUSMATRIX_INSTG_ERR_CANCEL_EN
      exp_hold("s5_error_idle", 32'h5000_0020, TRANS_IDLE, 1'b1, 3'd2, 3'd0, 4'h3);
      step(); drive(1'b1, 32'h5000_0028, TRANS_NONSEQ, 1'b1, 3'd2, 3'd0, 4'h3, 1'b0, 1'b0, 1'b1, RESP_OKAY);
      exp_pass("s5_cancelled_pass");
`else
      exp_hold("s5_error_ignored", 32'h5000_0020, TRANS_NONSEQ, 1'b1, 3'd2, 3'd0, 4'h3);
      step(); drive(1'b1, 32'h5000_0028, TRANS_NONSEQ, 1'b1, 3'd2, 3'd0, 4'h3, 1'b0, 1'b0, 1'b1, RESP_OKAY);
      exp_hold("s5_still_hold", 32'h5000_0020, TRANS_NONSEQ, 1'b1, 3'd2, 3'd0, 4'h3);
      step(); drive(1'b1, 32'h5000_002C, TRANS_NONSEQ, 1'b1, 3'd2, 3'd0, 4'h3, 1'b0, 1'b1, 1'b1, RESP_OKAY);
      exp_hold("s5_grant_cycle", 32'h5000_0020, TRANS_NONSEQ, 1'b1, 3'd2, 3'd0, 4'h3);
`endif
      step(); drive(1'b0, 32'h0, TRANS_IDLE, 1'b0, 3'd0, 3'd0, 4'h0, 1'b1, 1'b1, 1'b1, RESP_OKAY);
      exp_pass("s5_final_pass");

      repeat (3) @(posedge HCLK);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got=%0d pending exp=0", exp_q.size());
      end

      // final report
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
